// File: rtl/tour_len_eval.sv
// tour_len_eval: snapshots a tour, sums its Manhattan edge lengths one edge per cycle,
// checks it is a permutation and tracks the best valid length seen.
module tour_len_eval #(
    parameter int N  = 64,
    parameter int CW = 8,
    parameter int IW = 6,
    parameter int LW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0][CW-1:0]   xs,
    input  logic [N-1:0][CW-1:0]   ys,
    input  logic [N-1:0][IW-1:0]   path,
    input  logic                   start,
    input  logic                   clear_best,
    output logic                   busy,
    output logic                   done,
    output logic [LW-1:0]          len,
    output logic                   perm_ok,
    output logic [LW-1:0]          best_len,
    output logic                   best_valid,
    output logic                   improved
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t                 r_state, w_next;
    logic [N-1:0][IW-1:0]   r_snap;
    logic [LW-1:0]          r_acc;
    logic [IW-1:0]          r_i;
    logic [N-1:0]           r_seen;
    logic                   r_dup;
    logic [IW-1:0]          w_a, w_b;
    logic [CW:0]            w_dx, w_dy;
    logic [CW-1:0]          w_adx, w_ady;
    logic [LW-1:0]          w_step;
    logic                   w_better;

    always_comb begin
        w_a      = r_snap[r_i];
        w_b      = r_snap[r_i + IW'(1)];
        w_dx     = {1'b0, xs[w_a]} - {1'b0, xs[w_b]};
        w_dy     = {1'b0, ys[w_a]} - {1'b0, ys[w_b]};
        w_adx    = w_dx[CW] ? CW'(-w_dx) : w_dx[CW-1:0];
        w_ady    = w_dy[CW] ? CW'(-w_dy) : w_dy[CW-1:0];
        w_step   = LW'(w_adx) + LW'(w_ady);
        w_better = ~r_dup && (~best_valid || r_acc < best_len);
        busy     = r_state == S_RUN;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_next = (r_i == IW'(N-1)) ? S_DONE : S_RUN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap     <= '0;
            r_acc      <= '0;
            r_i        <= '0;
            r_seen     <= '0;
            r_dup      <= 1'b0;
            done       <= 1'b0;
            improved   <= 1'b0;
            len        <= '0;
            perm_ok    <= 1'b0;
            best_len   <= '1;
            best_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            improved <= 1'b0;
            if (clear_best) begin
                best_len   <= '1;
                best_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: if (start) begin
                    r_snap <= path;
                    r_acc  <= '0;
                    r_i    <= '0;
                    r_seen <= '0;
                    r_dup  <= 1'b0;
                end
                S_RUN: begin
                    r_acc       <= r_acc + w_step;
                    r_seen[w_a] <= 1'b1;
                    r_dup       <= r_dup | r_seen[w_a];
                    r_i         <= r_i + IW'(1);
                end
                S_DONE: begin
                    len     <= r_acc;
                    perm_ok <= ~r_dup;
                    done    <= 1'b1;
                    // a simultaneous clear takes precedence over a new best
                    if (w_better && !clear_best) begin
                        best_len   <= r_acc;
                        best_valid <= 1'b1;
                        improved   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tour_len_eval.sv
// tb_tour_len_eval: table vectors, randomized tours against a behavioural model,
// and hand sequences for mid-run start, mid-run reset and clear-at-done.
module tb_tour_len_eval;
    localparam int N = 64, CW = 8, IW = 6, LW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0][CW-1:0] xs, ys;
    logic [N-1:0][IW-1:0] path;
    logic start = 1'b0, clear_best = 1'b0;
    logic busy, done, perm_ok, best_valid, improved;
    logic [LW-1:0] len, best_len;

    int n_pass = 0, n_chk = 0;
    int m_best = 16'hFFFF;
    bit m_bv = 0;

    typedef struct {
        string name;
        int    kind;
        bit    pre_clr;
        int    e_len;
        bit    e_ok;
        bit    e_imp;
        int    e_best;
    } vec_t;
    vec_t tbl[5];

    tour_len_eval #(.N(N), .CW(CW), .IW(IW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .xs(xs), .ys(ys), .path(path), .start(start),
        .clear_best(clear_best), .busy(busy), .done(done), .len(len),
        .perm_ok(perm_ok), .best_len(best_len), .best_valid(best_valid),
        .improved(improved)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic int ref_len();
        int s = 0;
        for (int i = 0; i < N; i++) begin
            int a = int'(path[i]);
            int b = int'(path[(i + 1) % N]);
            s += iabs(int'(xs[a]) - int'(xs[b])) + iabs(int'(ys[a]) - int'(ys[b]));
        end
        return s;
    endfunction

    function automatic bit ref_perm();
        bit seen[N];
        foreach (seen[i]) seen[i] = 0;
        for (int i = 0; i < N; i++) begin
            if (seen[path[i]]) return 0;
            seen[path[i]] = 1;
        end
        return 1;
    endfunction

    task automatic setup(input int kind);
        for (int i = 0; i < N; i++) begin
            xs[i] = CW'(i);
            ys[i] = (kind == 0) ? CW'(i) : '0;
            case (kind)
                1:       path[i] = IW'((i % 2) ? i / 2 + 32 : i / 2);
                3:       path[i] = IW'(N - 1 - i);
                default: path[i] = IW'(i);
            endcase
        end
        if (kind == 4) path[1] = '0;
    endtask

    task automatic do_clear();
        @(negedge clk) clear_best = 1'b1;
        @(negedge clk) clear_best = 1'b0;
        m_best = 16'hFFFF;
        m_bv = 0;
    endtask

    task automatic predict(input bit clr_done, output int e_len, output bit e_ok,
                           output bit e_imp, output int e_best, output bit e_bv);
        e_len = ref_len();
        e_ok  = ref_perm();
        e_imp = e_ok && (!m_bv || e_len < m_best) && !clr_done;
        if (e_imp) begin m_best = e_len; m_bv = 1; end
        if (clr_done) begin m_best = 16'hFFFF; m_bv = 0; end
        e_best = m_best;
        e_bv = m_bv;
    endtask

    task automatic eval(input string tag, input int e_len, input bit e_ok, input bit e_imp,
                        input int e_best, input bit e_bv, input bit clr_done, input bit rnd);
        int e, bcnt, dcnt;
        bit got;
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        bcnt = busy;
        e = 0;
        got = 0;
        while (!got && e < 3 * N) begin
            @(posedge clk) #1 e++;
            if (done) got = 1;
            else bcnt += busy;
            clear_best = clr_done && e == N;
            start = rnd && e == 10;
            if (rnd && !got) for (int j = 0; j < N; j++) path[j] = IW'($urandom);
        end
        clear_best = 1'b0;
        start = 1'b0;
        check({tag, " latency"}, got ? e : -1, N + 1);
        check({tag, " busy_cycles"}, bcnt, N);
        check({tag, " len"}, len, e_len);
        check({tag, " perm_ok"}, perm_ok, e_ok);
        check({tag, " improved"}, improved, e_imp);
        check({tag, " best_len"}, best_len, e_best);
        check({tag, " best_valid"}, best_valid, e_bv);
        if (rnd) begin
            dcnt = 0;
            for (int k = 0; k < N + 8; k++) begin
                @(posedge clk) #1 dcnt += done;
            end
            check({tag, " extra_done"}, dcnt, 0);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " improved"}, improved, 0);
        check({tag, " len"}, len, 0);
        check({tag, " perm_ok"}, perm_ok, 0);
        check({tag, " best_len"}, best_len, 16'hFFFF);
        check({tag, " best_valid"}, best_valid, 0);
    endtask

    initial begin
        int e_len, e_best;
        bit e_ok, e_imp, e_bv;
        tbl[0] = '{"diag",  0, 0,  252, 1, 1,  252};
        tbl[1] = '{"alt",   1, 1, 2048, 1, 1, 2048};
        tbl[2] = '{"ident", 2, 0,  126, 1, 1,  126};
        tbl[3] = '{"rev",   3, 0,  126, 1, 0,  126};
        tbl[4] = '{"dup",   4, 0,  126, 0, 0,  126};
        setup(0);
        #12;
        check_reset("reset");
        @(negedge clk) rst = 1'b1;

        foreach (tbl[v]) begin
            setup(tbl[v].kind);
            if (tbl[v].pre_clr) do_clear();
            eval(tbl[v].name, tbl[v].e_len, tbl[v].e_ok, tbl[v].e_imp, tbl[v].e_best, 1, 0, 0);
            m_best = tbl[v].e_best;
            m_bv = 1;
        end

        for (int t = 0; t < 8; t++) begin
            int p[N];
            for (int i = 0; i < N; i++) begin
                xs[i] = CW'($urandom);
                ys[i] = CW'($urandom);
                p[i] = i;
            end
            for (int i = N - 1; i > 0; i--) begin
                int j = $urandom_range(i, 0);
                int tmp = p[i];
                p[i] = p[j];
                p[j] = tmp;
            end
            if (t % 3 == 2) p[$urandom_range(N - 1, 0)] = p[$urandom_range(N - 1, 0)];
            for (int i = 0; i < N; i++) path[i] = IW'(p[i]);
            if (t == 4) do_clear();
            predict(0, e_len, e_ok, e_imp, e_best, e_bv);
            eval($sformatf("rand%0d", t), e_len, e_ok, e_imp, e_best, e_bv, 0, 0);
        end

        setup(0);
        do_clear();
        predict(0, e_len, e_ok, e_imp, e_best, e_bv);
        eval("live_path", e_len, e_ok, e_imp, e_best, e_bv, 0, 1);

        setup(0);
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset("midrun_reset");
        m_best = 16'hFFFF;
        m_bv = 0;
        @(negedge clk) rst = 1'b1;
        begin
            int dcnt = 0;
            for (int k = 0; k < N + 8; k++) begin
                @(posedge clk) #1 dcnt += done;
            end
            check("midrun_reset no_done", dcnt, 0);
        end
        predict(0, e_len, e_ok, e_imp, e_best, e_bv);
        eval("after_reset", e_len, e_ok, e_imp, e_best, e_bv, 0, 0);

        setup(0);
        do_clear();
        predict(1, e_len, e_ok, e_imp, e_best, e_bv);
        eval("clear_at_done", e_len, e_ok, e_imp, e_best, e_bv, 1, 0);
        setup(2);
        predict(0, e_len, e_ok, e_imp, e_best, e_bv);
        eval("after_clear", e_len, e_ok, e_imp, e_best, e_bv, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
